// File: rtl/mioc_od_line_rx.sv
// mioc_od_line_rx
//   Receive end of a single-wire open-drain MIOC line (wired-AND, external
//   pullup, idle high). The pad node is synchronized and glitch-filtered, then
//   low-pulse widths are classified: short low = 1, long low = 0, very long
//   low = bus reset. Bits assemble LSB first into DATA_W-bit words, which are
//   presented through a one-entry holding register.
//
// Ports
//   clk         in   1       single clock, rising edge
//   rst_n       in   1       asynchronous active-low reset
//   od_line     in   1       pulled-up open-drain node, asynchronous to clk
//   data_ready  in   1       consumer accepts data_out
//   ovr_clr     in   1       synchronous clear of overrun
//   data_out    out  DATA_W  received word
//   data_valid  out  1       holding register full
//   overrun     out  1       sticky: a word was dropped
//   frame_err   out  1       one-cycle pulse: partial word aborted
//   bus_reset   out  1       one-cycle pulse: reset pulse detected
//   line_filt   out  1       synchronized, filtered line level
//
// Handshake: a word transfers on every cycle where data_valid && data_ready
// are both high at the rising clock edge. data_valid and data_out hold steady
// until that transfer; data_ready may change freely and is never required
// before data_valid is raised.
module mioc_od_line_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT        = 3,
  parameter int BIT_THRESH  = 16,
  parameter int RESET_MIN   = 64,
  parameter int IDLE_TMO    = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              od_line,
  input  logic              data_ready,
  input  logic              ovr_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              overrun,
  output logic              frame_err,
  output logic              bus_reset,
  output logic              line_filt
);

  localparam int FW = $clog2(FILT + 1);
  localparam int LW = $clog2(RESET_MIN + 1);
  localparam int HW = $clog2(IDLE_TMO + 1);
  localparam int BW = $clog2(DATA_W + 1);

  localparam logic [FW-1:0] FILT_LAST = FW'(FILT - 1);
  localparam logic [LW-1:0] LOW_MAX   = LW'(RESET_MIN);
  localparam logic [LW-1:0] LOW_LAST  = LW'(RESET_MIN - 1);
  localparam logic [LW-1:0] BIT_LIM   = LW'(BIT_THRESH);
  localparam logic [HW-1:0] HIGH_MAX  = HW'(IDLE_TMO);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_RSTP = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sample;
  logic [FW-1:0]          filt_cnt;
  logic [1:0]             state;
  logic [LW-1:0]          low_cnt;
  logic [HW-1:0]          high_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_W-1:0]      shift;
  logic [DATA_W-1:0]      shift_next;
  logic                   bit_val;
  logic                   word_done;
  logic                   complete;

  // Synchronizer resets high so reset release never looks like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], od_line};
  end

  assign sample = sync_q[SYNC_STAGES-1];

  // The level flips on the FILT-th consecutive differing sample, giving an
  // od_line-to-line_filt latency of SYNC_STAGES + FILT clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_cnt  <= '0;
      line_filt <= 1'b1;
    end else if (sample == line_filt) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FILT_LAST) begin
      filt_cnt  <= '0;
      line_filt <= sample;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  // low_cnt equals the number of cycles line_filt has been low.
  assign bit_val   = (low_cnt < BIT_LIM);
  assign word_done = (bit_cnt == BIT_LAST);
  assign complete  = (state == S_LOW) && line_filt && word_done;

  always_comb begin
    shift_next = shift;
    for (int i = 0; i < DATA_W; i++) begin
      if (bit_cnt == BW'(i)) shift_next[i] = bit_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      low_cnt   <= '0;
      high_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
      bus_reset <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      bus_reset <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!line_filt) begin
            state   <= S_LOW;
            low_cnt <= LW'(1);
          end
        end
        S_LOW: begin
          if (line_filt) begin
            shift    <= shift_next;
            bit_cnt  <= word_done ? '0 : bit_cnt + 1'b1;
            high_cnt <= '0;
            state    <= S_HIGH;
          end else begin
            if (low_cnt != LOW_MAX) low_cnt <= low_cnt + 1'b1;
            if (low_cnt == LOW_LAST) state <= S_RSTP;
          end
        end
        S_HIGH: begin
          if (!line_filt) begin
            state   <= S_LOW;
            low_cnt <= LW'(1);
          end else if (high_cnt == HIGH_MAX) begin
            // Idle timeout: only a partial word counts as a framing error.
            if (bit_cnt != '0) frame_err <= 1'b1;
            bit_cnt <= '0;
            state   <= S_IDLE;
          end else begin
            high_cnt <= high_cnt + 1'b1;
          end
        end
        S_RSTP: begin
          if (line_filt) begin
            bus_reset <= 1'b1;
            if (bit_cnt != '0) frame_err <= 1'b1;
            bit_cnt <= '0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Holding register: a completed word loads unless the register is still
  // full and not being drained, in which case the new word is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (complete) begin
        if (!data_valid || data_ready) begin
          data_out   <= shift_next;
          data_valid <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
      if (complete && data_valid && !data_ready) overrun <= 1'b1;
      else if (ovr_clr)                          overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mioc_od_line_rx.sv
module tb_mioc_od_line_rx;

  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int FILT        = 3;
  localparam int BIT_THRESH  = 16;
  localparam int RESET_MIN   = 64;
  localparam int IDLE_TMO    = 256;
  localparam int L1          = 8;
  localparam int L0          = 30;
  localparam int GAP         = 20;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              od_line = 1'b1;
  logic              data_ready = 1'b0;
  logic              ovr_clr = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              overrun;
  logic              frame_err;
  logic              bus_reset;
  logic              line_filt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [DATA_W-1:0] exp_q[$];
  int fe_cnt = 0;
  int br_cnt = 0;
  int fe_cyc = 0;
  int br_cyc = 0;
  int last_rise_cyc = 0;
  logic filt_low_seen = 1'b0;
  logic ovr_seen = 1'b0;

  mioc_od_line_rx #(
    .DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES), .FILT(FILT),
    .BIT_THRESH(BIT_THRESH), .RESET_MIN(RESET_MIN), .IDLE_TMO(IDLE_TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .od_line(od_line), .data_ready(data_ready),
    .ovr_clr(ovr_clr), .data_out(data_out), .data_valid(data_valid),
    .overrun(overrun), .frame_err(frame_err), .bus_reset(bus_reset),
    .line_filt(line_filt)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor / scoreboard: sampled on the falling edge, away from input changes.
  always @(negedge clk) begin
    if (frame_err) begin fe_cnt++; fe_cyc = cyc; end
    if (bus_reset) begin br_cnt++; br_cyc = cyc; end
    if (!line_filt) filt_low_seen = 1'b1;
    if (overrun) ovr_seen = 1'b1;
    if (rst_n && data_valid && data_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_word observed=%0h expected=none", data_out);
      end
      if (exp_q.size() != 0) check("word", 32'(data_out), 32'(exp_q.pop_front()));
    end
  end

  // Driver tasks: all inputs change 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_pulse(input int l, input int gap);
    od_line = 1'b0;
    tick(l);
    od_line = 1'b1;
    last_rise_cyc = cyc;
    tick(gap);
  endtask

  // Low length from the bit value: below BIT_THRESH encodes 1, else 0.
  function automatic int bit_len(input logic b, input bit rnd);
    if (!rnd) return b ? L1 : L0;
    return b ? int'($urandom_range(FILT + 1, BIT_THRESH - 1))
             : int'($urandom_range(BIT_THRESH, RESET_MIN - 1));
  endfunction

  task automatic send_word(input logic [DATA_W-1:0] w, input bit rnd);
    for (int i = 0; i < DATA_W; i++)
      send_pulse(bit_len(w[i], rnd), rnd ? int'($urandom_range(8, 40)) : GAP);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin tick(1); n++; end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data_out"}, 32'(data_out), 32'd0);
    check({tag, "_data_valid"}, 32'(data_valid), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check({tag, "_bus_reset"}, 32'(bus_reset), 32'd0);
    check({tag, "_line_filt"}, 32'(line_filt), 32'd1);
  endtask

  initial begin
    int fe0, br0;
    logic [DATA_W-1:0] w;
    int ls[DATA_W];

    // Reset
    rst_n = 1'b0;
    tick(3);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick(5);

    // 1: nominal word, then a long idle that must not flag a complete word
    data_ready = 1'b1;
    fe0 = fe_cnt;
    exp_q.push_back(8'hA5);
    send_word(8'hA5, 1'b0);
    wait_drain("t1_drain");
    tick(300);
    check("t1_frame_err", 32'(fe_cnt - fe0), 32'd0);
    check("t1_overrun", 32'(overrun), 32'd0);
    check("t1_valid_dropped", 32'(data_valid), 32'd0);

    // 2: short glitch invisible; FILT+1 cycle low is a 1 bit
    filt_low_seen = 1'b0;
    od_line = 1'b0;
    tick(2);
    od_line = 1'b1;
    tick(20);
    check("t2_glitch_line_filt", 32'(filt_low_seen), 32'd0);
    w = 8'($urandom) | 8'h01;
    exp_q.push_back(w);
    send_pulse(4, GAP);
    check("t2_short_low_seen", 32'(filt_low_seen), 32'd1);
    for (int i = 1; i < DATA_W; i++) send_pulse(bit_len(w[i], 1'b1), GAP);
    wait_drain("t2_drain");

    // 3: idle timeout on a partial word, exact timing
    fe0 = fe_cnt;
    w = 8'($urandom);
    for (int i = 0; i < 3; i++) send_pulse(bit_len(w[i], 1'b1), GAP);
    tick(300);
    check("t3_frame_err_count", 32'(fe_cnt - fe0), 32'd1);
    check("t3_frame_err_time", 32'(fe_cyc - last_rise_cyc),
          32'(SYNC_STAGES + FILT + 1 + IDLE_TMO + 1));
    check("t3_no_word", 32'(data_valid), 32'd0);
    exp_q.push_back(8'h3C);
    send_word(8'h3C, 1'b0);
    wait_drain("t3_drain");
    check("t3_frame_err_after", 32'(fe_cnt - fe0), 32'd1);

    // 4: bus reset after two bits
    fe0 = fe_cnt;
    br0 = br_cnt;
    send_pulse(L1, GAP);
    send_pulse(L0, GAP);
    send_pulse(80, GAP);
    check("t4_bus_reset", 32'(br_cnt - br0), 32'd1);
    check("t4_frame_err", 32'(fe_cnt - fe0), 32'd1);
    check("t4_same_cycle", 32'(br_cyc), 32'(fe_cyc));
    check("t4_no_word", 32'(data_valid), 32'd0);
    exp_q.push_back(8'hFF);
    send_word(8'hFF, 1'b0);
    wait_drain("t4_drain");

    // Boundary lengths: 15/16 straddle BIT_THRESH, 63 just below RESET_MIN
    ls = '{15, 16, RESET_MIN - 1, 4, 15, 16, RESET_MIN - 1, 4};
    for (int i = 0; i < DATA_W; i++) w[i] = (ls[i] < BIT_THRESH);
    br0 = br_cnt;
    exp_q.push_back(w);
    for (int i = 0; i < DATA_W; i++) send_pulse(ls[i], GAP);
    wait_drain("bnd_drain");
    check("bnd_no_bus_reset", 32'(br_cnt - br0), 32'd0);
    fe0 = fe_cnt;
    send_pulse(RESET_MIN, GAP);
    check("bnd_reset_min", 32'(br_cnt - br0), 32'd1);
    check("bnd_reset_idle_fe", 32'(fe_cnt - fe0), 32'd0);

    // Randomized words with random pulse lengths and gaps
    for (int k = 0; k < 10; k++) begin
      w = 8'($urandom);
      exp_q.push_back(w);
      send_word(w, 1'b1);
      wait_drain("rnd_drain");
    end

    // 5: overrun, clear, set-wins-over-clear, then drain
    data_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_word(8'h11, 1'b1);
    send_word(8'h22, 1'b1);
    check("t5_valid", 32'(data_valid), 32'd1);
    check("t5_data_out", 32'(data_out), 32'h11);
    check("t5_overrun", 32'(overrun), 32'd1);
    ovr_clr = 1'b1;
    tick(1);
    ovr_clr = 1'b0;
    check("t5_ovr_clr", 32'(overrun), 32'd0);
    ovr_seen = 1'b0;
    ovr_clr = 1'b1;
    send_word(8'h33, 1'b1);
    ovr_clr = 1'b0;
    tick(1);
    check("t5_set_wins", 32'(ovr_seen), 32'd1);
    check("t5_overrun_cleared", 32'(overrun), 32'd0);
    check("t5_data_kept", 32'(data_out), 32'h11);
    data_ready = 1'b1;
    wait_drain("t5_drain");
    tick(1);
    check("t5_valid_drop", 32'(data_valid), 32'd0);

    // 6: async reset in the middle of a word with a full holding register
    data_ready = 1'b0;
    send_word(8'hC3, 1'b1);
    check("t6_valid_before", 32'(data_valid), 32'd1);
    w = 8'($urandom);
    for (int i = 0; i < 4; i++) send_pulse(bit_len(w[i], 1'b1), GAP);
    od_line = 1'b0;
    tick(5);
    #2;
    rst_n = 1'b0;
    od_line = 1'b1;
    #1;
    check_reset_outputs("t6_rst");
    tick(3);
    rst_n = 1'b1;
    tick(10);
    fe0 = fe_cnt;
    data_ready = 1'b1;
    exp_q.push_back(8'h5A);
    send_word(8'h5A, 1'b0);
    wait_drain("t6_drain");
    check("t6_frame_err", 32'(fe_cnt - fe0), 32'd0);

    tick(5);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
